// File: rtl/turn_judge.sv
// Per-turn referee for Chicken Cha-Cha-Cha: compares the picked card's picture with the
// tile ahead of the active player and either strobes that player's counter or passes the turn.
module turn_judge #(
  parameter int REVEAL_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] N,
  input  logic       btn,
  input  logic [3:0] card_sel,
  input  logic [4:0] p1_pos,
  input  logic [4:0] p2_pos,
  input  logic [4:0] p3_pos,
  input  logic [4:0] p4_pos,
  output logic [1:0] turn,
  output logic [3:0] p_da,
  output logic       mv,
  output logic       reveal,
  output logic       match,
  output logic       bad_sel,
  output logic       busy
);

  localparam int CW = (REVEAL_CYC < 2) ? 1 : $clog2(REVEAL_CYC);
  localparam logic [CW-1:0] CNT_LOAD = CW'((REVEAL_CYC > 0) ? REVEAL_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_JUDGE,
    S_REVEAL,
    S_SETUP,
    S_MOVE,
    S_PASS
  } state_t;

  state_t        state, state_d;
  logic          btn_q;
  logic [3:0]    card_q, card_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    turn_d;
  logic [3:0]    p_da_d;
  logic          mv_d, reveal_d, match_d, bad_sel_d;

  logic          pick_edge;
  logic [2:0]    n_eff;
  logic [2:0]    turn_inc;
  logic [4:0]    cur_pos;
  logic          match_now;

  // Card k shows picture (7*k) mod 12; a lookup keeps the multiplier out of the netlist.
  function automatic logic [3:0] card_pic(input logic [3:0] k);
    case (k)
      4'd0:    card_pic = 4'd0;
      4'd1:    card_pic = 4'd7;
      4'd2:    card_pic = 4'd2;
      4'd3:    card_pic = 4'd9;
      4'd4:    card_pic = 4'd4;
      4'd5:    card_pic = 4'd11;
      4'd6:    card_pic = 4'd6;
      4'd7:    card_pic = 4'd1;
      4'd8:    card_pic = 4'd8;
      4'd9:    card_pic = 4'd3;
      4'd10:   card_pic = 4'd10;
      4'd11:   card_pic = 4'd5;
      default: card_pic = 4'd0;
    endcase
  endfunction

  // Picture on the tile directly ahead; the 24-tile track wraps from 23 back to 0.
  function automatic logic [3:0] tile_pic(input logic [4:0] pos);
    logic [5:0] nxt;
    nxt      = (pos == 5'd23) ? 6'd0 : {1'b0, pos} + 6'd1;
    tile_pic = 4'(nxt % 6'd12);
  endfunction

  assign pick_edge = btn & ~btn_q;
  assign n_eff     = (N >= 5'd2 && N <= 5'd4) ? N[2:0] : 3'd2;
  assign turn_inc  = {1'b0, turn} + 3'd1;
  assign busy      = (state != S_IDLE);

  always_comb begin
    case (turn)
      2'd0:    cur_pos = p1_pos;
      2'd1:    cur_pos = p2_pos;
      2'd2:    cur_pos = p3_pos;
      default: cur_pos = p4_pos;
    endcase
  end

  assign match_now = (card_pic(card_q) == tile_pic(cur_pos));

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state;
    card_d    = card_q;
    cnt_d     = cnt;
    turn_d    = turn;
    match_d   = match;
    reveal_d  = 1'b0;
    bad_sel_d = 1'b0;
    p_da_d    = 4'b0000;
    mv_d      = 1'b0;

    case (state)
      S_IDLE: begin
        if (pick_edge) begin
          if (card_sel <= 4'd11) begin
            card_d  = card_sel;
            state_d = S_JUDGE;
          end else begin
            bad_sel_d = 1'b1;
          end
        end
      end
      S_JUDGE: begin
        match_d  = match_now;
        reveal_d = 1'b1;
        cnt_d    = CNT_LOAD;
        if (REVEAL_CYC == 0) state_d = match_now ? S_SETUP : S_PASS;
        else                 state_d = S_REVEAL;
      end
      S_REVEAL: begin
        if (cnt == '0) begin
          state_d = match ? S_SETUP : S_PASS;
        end else begin
          cnt_d    = cnt - CW'(1);
          reveal_d = 1'b1;
        end
      end
      S_SETUP: state_d = S_MOVE;
      S_MOVE:  state_d = S_IDLE;
      S_PASS: begin
        turn_d  = (turn_inc >= n_eff) ? 2'd0 : turn_inc[1:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so p_da settles a full cycle before mv rises.
    if (state_d == S_SETUP || state_d == S_MOVE) p_da_d = 4'b0001 << turn;
    mv_d = (state_d == S_MOVE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      btn_q   <= 1'b0;
      card_q  <= 4'd0;
      cnt     <= '0;
      turn    <= 2'd0;
      p_da    <= 4'b0000;
      mv      <= 1'b0;
      reveal  <= 1'b0;
      match   <= 1'b0;
      bad_sel <= 1'b0;
    end else begin
      state   <= state_d;
      btn_q   <= btn;
      card_q  <= card_d;
      cnt     <= cnt_d;
      turn    <= turn_d;
      p_da    <= p_da_d;
      mv      <= mv_d;
      reveal  <= reveal_d;
      match   <= match_d;
      bad_sel <= bad_sel_d;
    end
  end

endmodule

// File: tb/tb_turn_judge.sv
// Directed bench for turn_judge: hand-computed verdicts, turn rotation, bad picks,
// held/extra button edges and asynchronous reset mid-pick.
module tb_turn_judge;

  localparam int RC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] N = 5'd2;
  logic       btn = 1'b0;
  logic [3:0] card_sel = 4'd0;
  logic [4:0] p1_pos = 5'd0, p2_pos = 5'd0, p3_pos = 5'd0, p4_pos = 5'd0;
  logic [1:0] turn;
  logic [3:0] p_da;
  logic       mv, reveal, match, bad_sel, busy;

  int n_cmp  = 0;
  int n_bad  = 0;
  int mv_cnt = 0;

  always #5 clk = ~clk;

  turn_judge #(.REVEAL_CYC(RC)) dut (
    .clk      (clk),
    .rst      (rst),
    .N        (N),
    .btn      (btn),
    .card_sel (card_sel),
    .p1_pos   (p1_pos),
    .p2_pos   (p2_pos),
    .p3_pos   (p3_pos),
    .p4_pos   (p4_pos),
    .turn     (turn),
    .p_da     (p_da),
    .mv       (mv),
    .reveal   (reveal),
    .match    (match),
    .bad_sel  (bad_sel),
    .busy     (busy)
  );

  always @(posedge mv) mv_cnt++;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, " turn"},   8'(turn),    8'd0);
    check({nm, " p_da"},   8'(p_da),    8'd0);
    check({nm, " mv"},     8'(mv),      8'd0);
    check({nm, " reveal"}, 8'(reveal),  8'd0);
    check({nm, " match"},  8'(match),   8'd0);
    check({nm, " badsel"}, 8'(bad_sel), 8'd0);
    check({nm, " busy"},   8'(busy),    8'd0);
  endtask

  // Sample point i is the falling edge after rising edge t+i, t being the edge that sees the pick.
  task automatic pick(input string nm, input logic [3:0] card, input logic exp_m,
                      input logic [3:0] exp_pda, input logic [1:0] exp_turn,
                      input int hold, input int glitch, input int rst_at);
    int mv0;
    int last;
    int exp_mv;
    bit aborted;
    mv0     = mv_cnt;
    aborted = 1'b0;
    last    = (hold > RC + 4) ? hold + 1 : RC + 4;
    @(negedge clk);
    card_sel = card;
    btn      = 1'b1;
    @(posedge clk);
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      if (!aborted) begin
        if (i == 0) check({nm, " busy@t"}, 8'(busy), 8'd1);
        if (i == 1) begin
          check({nm, " reveal@t+1"}, 8'(reveal), 8'd1);
          check({nm, " match"},      8'(match),  8'(exp_m));
        end
        if (i == RC + 1) begin
          check({nm, " reveal_off"}, 8'(reveal), 8'd0);
          check({nm, " p_da@setup"}, 8'(p_da),   exp_m ? 8'(exp_pda) : 8'd0);
          check({nm, " mv@setup"},   8'(mv),     8'd0);
          check({nm, " busy@setup"}, 8'(busy),   8'd1);
        end
        if (i == RC + 2) begin
          check({nm, " mv@move"},   8'(mv),   exp_m ? 8'd1 : 8'd0);
          check({nm, " p_da@move"}, 8'(p_da), exp_m ? 8'(exp_pda) : 8'd0);
          if (!exp_m) check({nm, " turn@pass"}, 8'(turn), 8'(exp_turn));
        end
        if (i == RC + 3 && exp_m) begin
          check({nm, " mv@idle"},   8'(mv),   8'd0);
          check({nm, " p_da@idle"}, 8'(p_da), 8'd0);
          check({nm, " busy@idle"}, 8'(busy), 8'd0);
        end
      end
      if (i == rst_at) begin
        #2 rst = 1'b0;
        #1 check_zero({nm, " rst"});
        aborted = 1'b1;
        #1 rst = 1'b1;
      end
      if (i == hold) btn = 1'b0;
      if (glitch >= 0 && i == glitch) btn = 1'b0;
      if (glitch >= 0 && i == glitch + 1) btn = 1'b1;
    end
    exp_mv = (exp_m && (rst_at < 0 || rst_at >= RC + 2)) ? 1 : 0;
    check({nm, " mv_pulses"}, 8'(mv_cnt - mv0), 8'(exp_mv));
    check({nm, " turn_end"},  8'(turn), aborted ? 8'd0 : 8'(exp_turn));
    check({nm, " busy_end"},  8'(busy), 8'd0);
  endtask

  task automatic bad_pick(input logic [1:0] exp_turn);
    int mv0;
    mv0 = mv_cnt;
    @(negedge clk);
    card_sel = 4'd12;
    btn      = 1'b1;
    @(negedge clk);
    check("bad badsel_pulse", 8'(bad_sel), 8'd1);
    check("bad busy",         8'(busy),    8'd0);
    btn = 1'b0;
    @(negedge clk);
    check("bad badsel_clear", 8'(bad_sel), 8'd0);
    check("bad busy2",        8'(busy),    8'd0);
    check("bad turn",         8'(turn),    8'(exp_turn));
    check("bad mv",           8'(mv_cnt - mv0), 8'd0);
  endtask

  initial begin
    int mv0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // N=2, P1 at 0: card 7 (pic 1) matches tile 1.
    pick("match", 4'd7, 1'b1, 4'b0001, 2'd0, 0, -1, -1);
    // Card 0 (pic 0) misses tile 1 for both players.
    pick("miss1", 4'd0, 1'b0, 4'b0000, 2'd1, 0, -1, -1);
    pick("miss2", 4'd0, 1'b0, 4'b0000, 2'd0, 0, -1, -1);
    bad_pick(2'd0);

    // N=3: rotate to P3 at 23; tile ahead is 0 (pic 0) = card 0; card 1 (pic 7) misses.
    N = 5'd3;
    pick("n3_miss_a", 4'd0, 1'b0, 4'b0000, 2'd1, 0, -1, -1);
    pick("n3_miss_b", 4'd0, 1'b0, 4'b0000, 2'd2, 0, -1, -1);
    p3_pos = 5'd23;
    pick("wrap_hit",  4'd0, 1'b1, 4'b0100, 2'd2, 0, -1, -1);
    pick("wrap_miss", 4'd1, 1'b0, 4'b0000, 2'd0, 0, -1, -1);

    // Button held 20 cycles with an extra edge during REVEAL: one pick only.
    N = 5'd2;
    pick("held", 4'd7, 1'b1, 4'b0001, 2'd0, 20, 2, -1);

    // Invalid N behaves as 2 players.
    N = 5'd7;
    pick("n7_miss_a", 4'd0, 1'b0, 4'b0000, 2'd1, 0, -1, -1);
    pick("n7_miss_b", 4'd0, 1'b0, 4'b0000, 2'd0, 0, -1, -1);
    pick("n7_miss_c", 4'd0, 1'b0, 4'b0000, 2'd1, 0, -1, -1);

    // Reset mid-REVEAL (turn 1 -> 0), then mid-MOVE.
    N = 5'd2;
    pick("rst_reveal", 4'd7, 1'b1, 4'b0010, 2'd1, 0, -1, 2);
    pick("rst_move",   4'd7, 1'b1, 4'b0001, 2'd0, 0, -1, RC + 2);
    mv0 = mv_cnt;
    repeat (10) @(negedge clk);
    check("post_rst mv", 8'(mv_cnt - mv0), 8'd0);
    check("post_rst busy", 8'(busy), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
